// File: rtl/gtech_reduce_pipe_if.sv
// gtech_reduce_pipe_if: operand/result handshake bundle
// master drives operand side, slave is the reduction pipe
interface gtech_reduce_pipe_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] a;
  logic [2:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic             z;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, op, in_valid, out_ready,
    input  in_ready, z, out_valid
  );

  modport slave (
    input  a, op, in_valid, out_ready,
    output in_ready, z, out_valid
  );
endinterface

// File: rtl/gtech_reduce_pipe.sv
// gtech_reduce_pipe: pipelined FANIN-ary OR/AND(/XOR) reduction
// optional XOR class enabled by GTECH_REDUCE_XOR_EN
module gtech_reduce_pipe #(
  parameter int WIDTH = 64,
  parameter int FANIN = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  gtech_reduce_pipe_if.slave io_bus
);

  function automatic int lvl_w(input int lvl);
    int c;
    c = WIDTH;
    for (int k = 0; k < lvl; k++) c = (c + FANIN - 1) / FANIN;
    return c;
  endfunction

  function automatic int calc_stages();
    int c;
    int n;
    c = WIDTH;
    n = 0;
    while (c > 1) begin
      c = (c + FANIN - 1) / FANIN;
      n++;
    end
    return (n < 1) ? 1 : n;
  endfunction

  localparam int STAGES = calc_stages();

  // one tree level: FANIN-bit chunks from LSB, short chunk padded with identity
  function automatic logic [WIDTH-1:0] red_lvl(
    input logic [WIDTH-1:0] v,
    input int               win,
    input logic [2:0]       op
  );
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] sh;
    logic             is_x;
    logic             is_a;
    logic             acc;
    logic             b;
    int               idx;
    res  = '0;
    is_x = op[2];
    is_a = op[1] & ~op[2];
    for (int j = 0; j < WIDTH; j++) begin
      acc = is_a;
      for (int i = 0; i < FANIN; i++) begin
        idx = j * FANIN + i;
        sh  = v >> idx;
        b   = (idx < win) ? sh[0] : is_a;
        if (is_x)      acc = acc ^ b;
        else if (is_a) acc = acc & b;
        else           acc = acc | b;
      end
      res[j] = acc;
    end
    return res;
  endfunction

  function automatic logic red_top(
    input logic [WIDTH-1:0] v,
    input int               win,
    input logic [2:0]       op
  );
    logic [WIDTH-1:0] t;
    t = red_lvl(v, win, op);
    return t[0];
  endfunction

  logic       w_adv;
  logic [2:0] w_op;
  logic       r_z;
  logic       r_ov;

`ifdef GTECH_REDUCE_XOR_EN
  assign w_op = io_bus.op;
`else
  assign w_op = {1'b0, io_bus.op[1:0]};
`endif

  assign w_adv           = io_bus.out_ready | ~r_ov;
  assign io_bus.in_ready = w_adv;
  assign io_bus.z        = r_z;
  assign io_bus.out_valid = r_ov;

  if (STAGES == 1) begin : g_one
    // single level: reduce, invert and register in one step
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_z  <= 1'b0;
        r_ov <= 1'b0;
      end else if (w_adv) begin
        r_z  <= red_top(io_bus.a, WIDTH, w_op) ^ w_op[0];
        r_ov <= io_bus.in_valid;
      end
    end
  end else begin : g_multi
    localparam int NI = STAGES - 1;

    logic [WIDTH-1:0] r_dat [NI];
    logic [2:0]       r_op  [NI];
    logic             r_vld [NI];
    logic [WIDTH-1:0] w_nxt [NI];

    // next value of every intermediate level
    always_comb begin
      w_nxt[0] = red_lvl(io_bus.a, WIDTH, w_op);
      for (int k = 1; k < NI; k++)
        w_nxt[k] = red_lvl(r_dat[k-1], lvl_w(k), r_op[k-1]);
    end

    // global shift on advance; op rides along, inversion at the last level
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int k = 0; k < NI; k++) begin
          r_dat[k] <= '0;
          r_op[k]  <= '0;
          r_vld[k] <= 1'b0;
        end
        r_z  <= 1'b0;
        r_ov <= 1'b0;
      end else if (w_adv) begin
        r_dat[0] <= w_nxt[0];
        r_op[0]  <= w_op;
        r_vld[0] <= io_bus.in_valid;
        for (int k = 1; k < NI; k++) begin
          r_dat[k] <= w_nxt[k];
          r_op[k]  <= r_op[k-1];
          r_vld[k] <= r_vld[k-1];
        end
        r_z  <= red_top(r_dat[NI-1], lvl_w(NI), r_op[NI-1])
                ^ r_op[NI-1][0];
        r_ov <= r_vld[NI-1];
      end
    end
  end

endmodule
